// File: rtl/lc3b_writeback_buffer.sv
// lc3b_writeback_buffer
//   Single-entry eviction buffer between the L1 data cache memory port and
//   physical memory. A dirty-line writeback is absorbed in one cycle so the
//   refill read that usually follows can go to pmem first. The buffered line
//   drains to pmem after IDLE_FLUSH_DELAY idle cycles, or earlier when a
//   second writeback needs the slot.
//
//   Ports
//     clk, reset            rising-edge clock, synchronous active-high reset
//     mem_address/read/     cache-side request (held until mem_resp)
//       write/wdata
//     mem_rdata, mem_resp   cache-side response (mem_resp is a 1-cycle pulse)
//     pmem_address/read/    pmem-side request (held until pmem_resp)
//       write/wdata
//     pmem_rdata, pmem_resp pmem-side response
//
//   All outputs are registered.
module lc3b_writeback_buffer #(
    parameter int IDLE_FLUSH_DELAY = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [15:0]  mem_address,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [127:0] mem_wdata,
    output logic [127:0] mem_rdata,
    output logic         mem_resp,
    output logic [15:0]  pmem_address,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [127:0] pmem_wdata,
    input  logic [127:0] pmem_rdata,
    input  logic         pmem_resp
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RESP,
        S_READ,
        S_FLUSH
    } state_t;

    localparam logic [4:0] FLUSH_AT = 5'(IDLE_FLUSH_DELAY);

    state_t         state;
    logic           valid;
    logic [11:0]    tag;
    logic [127:0]   data;
    logic [3:0]     idle_cnt;

    // Byte offset within the line is irrelevant to a line buffer.
    logic           addr_offset_unused;
    assign addr_offset_unused = ^mem_address[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            valid        <= 1'b0;
            tag          <= '0;
            data         <= '0;
            idle_cnt     <= '0;
            mem_rdata    <= '0;
            mem_resp     <= 1'b0;
            pmem_address <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_wdata   <= '0;
        end else begin
            // Defaults: the response is a single-cycle pulse, and the idle
            // counter only survives in IDLE with nothing requested.
            mem_resp <= 1'b0;
            idle_cnt <= '0;

            unique case (state)
                S_IDLE: begin
                    if (mem_read) begin
                        // A simultaneous mem_write is ignored; the cache
                        // must reissue it.
                        if (valid && tag == mem_address[15:4]) begin
                            mem_rdata <= data;
                            mem_resp  <= 1'b1;
                            state     <= S_RESP;
                        end else begin
                            // Reads bypass a buffered line; it is not
                            // written out first.
                            pmem_read    <= 1'b1;
                            pmem_address <= {mem_address[15:4], 4'h0};
                            state        <= S_READ;
                        end
                    end else if (mem_write) begin
                        if (!valid) begin
                            tag      <= mem_address[15:4];
                            data     <= mem_wdata;
                            valid    <= 1'b1;
                            mem_resp <= 1'b1;
                            state    <= S_RESP;
                        end else begin
                            // Slot busy (even on a tag match, no merging):
                            // drain it, then take the write from IDLE again.
                            pmem_write   <= 1'b1;
                            pmem_address <= {tag, 4'h0};
                            pmem_wdata   <= data;
                            state        <= S_FLUSH;
                        end
                    end else if (valid) begin
                        // Flush once the counter would reach the delay; a
                        // delay of 0 or 1 therefore flushes on the first
                        // idle cycle.
                        if ({1'b0, idle_cnt} + 5'd1 >= FLUSH_AT) begin
                            pmem_write   <= 1'b1;
                            pmem_address <= {tag, 4'h0};
                            pmem_wdata   <= data;
                            state        <= S_FLUSH;
                        end else begin
                            idle_cnt <= idle_cnt + 4'd1;
                        end
                    end
                end

                // The cache still holds its request during this cycle.
                S_RESP: state <= S_IDLE;

                S_READ: begin
                    if (pmem_resp) begin
                        mem_rdata <= pmem_rdata;
                        pmem_read <= 1'b0;
                        mem_resp  <= 1'b1;
                        state     <= S_RESP;
                    end
                end

                // Never aborted; requests arriving meanwhile wait and then
                // see an empty buffer, so they are served from pmem.
                S_FLUSH: begin
                    if (pmem_resp) begin
                        valid      <= 1'b0;
                        pmem_write <= 1'b0;
                        state      <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lc3b_writeback_buffer.sv
// Self-checking bench for lc3b_writeback_buffer: reset checks, a directed
// vector table, hand-written multi-cycle sequences (auto-flush timing, reset
// during flush) and a randomized phase checked against a line-level memory
// model with a latency-programmable pmem responder.
module tb_lc3b_writeback_buffer;

    localparam int DELAY = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [15:0]  mem_address = '0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [127:0] mem_wdata = '0;
    logic [127:0] mem_rdata;
    logic         mem_resp;
    logic [15:0]  pmem_address;
    logic         pmem_read;
    logic         pmem_write;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata = '0;
    logic         pmem_resp = 1'b0;

    lc3b_writeback_buffer #(.IDLE_FLUSH_DELAY(DELAY)) dut (
        .clk(clk), .reset(reset),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
        .pmem_address(pmem_address), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_wdata(pmem_wdata),
        .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- pmem model ----------------
    logic [127:0] pmem_mem [logic [11:0]];
    int pm_lat = 2;
    int pm_wait = 0;
    int pm_reads = 0;
    int pm_writes = 0;

    function automatic logic [127:0] init_line(input logic [11:0] l);
        return {8{l, 4'hC}};
    endfunction

    function automatic logic [127:0] pm_get(input logic [11:0] l);
        return pmem_mem.exists(l) ? pmem_mem[l] : init_line(l);
    endfunction

    // Responds pm_lat cycles after an op is first seen; pulse is one cycle.
    always @(negedge clk) begin
        if (pmem_read || pmem_write) begin
            n_checks++;
            if ((pmem_read && pmem_write) || pmem_address[3:0] != 4'h0) begin
                n_fail++;
                $display("FAIL pmem_protocol: rd=%b wr=%b addr=%h, required one op and aligned address",
                         pmem_read, pmem_write, pmem_address);
            end
        end
        if (pmem_resp) pmem_resp = 1'b0;
        else if (reset) pm_wait = 0;
        else if (pmem_read || pmem_write) begin
            pm_wait++;
            if (pm_wait >= pm_lat) begin
                pm_wait = 0;
                pmem_resp = 1'b1;
                if (pmem_write) begin
                    pmem_mem[pmem_address[15:4]] = pmem_wdata;
                    pm_writes++;
                end else begin
                    pmem_rdata = pm_get(pmem_address[15:4]);
                    pm_reads++;
                end
            end
        end
    end

    // ---------------- cache-side driver ----------------
    task automatic do_req(input bit rd, input bit wr, input logic [15:0] addr,
                          input logic [127:0] wd, output int lat, output logic [127:0] rdat);
        bit got;
        got = 0;
        rdat = '0;
        @(negedge clk);
        mem_read = rd; mem_write = wr; mem_address = addr; mem_wdata = wd;
        lat = 0;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (mem_resp) begin
                got = 1;
                rdat = mem_rdata;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;
        if (!got) check("req_timeout", 128'(lat), 128'(0));
    endtask

    task automatic check_outputs_zero(input string name);
        check(name, {mem_rdata, mem_resp, pmem_address, pmem_read, pmem_write, pmem_wdata} == '0 ? 128'd0
                    : {mem_resp, pmem_read, pmem_write, pmem_address, 4'h0, mem_rdata[103:0]}, 128'd0);
    endtask

    typedef struct {
        bit           rd;
        bit           wr;
        logic [15:0]  addr;
        logic [127:0] wd;
        int           lat_pm;
        int           exp_lat;
        logic [127:0] exp_rdata;
        int           exp_reads;
        int           exp_writes;
    } vec_t;

    vec_t vecs[7];
    logic [127:0] D1, D2, D3, D4, D5;
    logic [127:0] ref_view [logic [11:0]];
    logic [11:0]  lines [6];

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, r0, w0, k;
        logic [127:0] rdat, exp;
        bit seen;

        D1 = {4{32'h1111_1111}};
        D2 = {4{32'h2222_2222}};
        D3 = {4{32'h3333_3333}};
        D4 = {4{32'h4444_4444}};
        D5 = {4{32'h5555_5555}};
        pmem_mem[12'h456] = D2;

        //           rd   wr   addr      wdata  pmL lat rdata             rds wrs
        vecs[0] = '{1'b0, 1'b1, 16'h1230, D1,     2, 1, 128'h0,            0, 0};
        vecs[1] = '{1'b1, 1'b0, 16'h1238, 128'h0, 2, 1, D1,                0, 0};
        vecs[2] = '{1'b1, 1'b0, 16'h4560, 128'h0, 5, 6, D2,                1, 0};
        vecs[3] = '{1'b0, 1'b1, 16'h7770, D3,     3, 5, 128'h0,            0, 1};
        vecs[4] = '{1'b0, 1'b1, 16'h7778, D4,     2, 4, 128'h0,            0, 1};
        vecs[5] = '{1'b1, 1'b1, 16'h9990, D5,     4, 5, init_line(12'h999), 1, 0};
        vecs[6] = '{1'b1, 1'b0, 16'h777C, 128'h0, 2, 1, D4,                0, 0};

        // ---- reset state ----
        repeat (3) @(negedge clk);
        check_outputs_zero("reset_during");
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("reset_after");

        // ---- auto-flush timing after a write into an empty buffer ----
        pm_lat = 2;
        w0 = pm_writes;
        do_req(1'b0, 1'b1, 16'h1230, D1, lat, rdat);
        check("af_write_lat", 128'(lat), 128'(1));
        seen = 0; k = 0;
        while (!seen && k < 20) begin
            @(negedge clk);
            k++;
            if (pmem_write) seen = 1;
        end
        check("af_start_cycle", 128'(k), 128'((DELAY > 1 ? DELAY : 1) + 1));
        check("af_addr", 128'(pmem_address), 128'(16'h1230));
        check("af_wdata", pmem_wdata, D1);
        k = 0;
        while (pmem_write && k < 20) begin @(negedge clk); k++; end
        check("af_writes", 128'(pm_writes - w0), 128'(1));
        check("af_pmem_line", pm_get(12'h123), D1);

        // ---- directed vector table ----
        for (int i = 0; i < 7; i++) begin
            pm_lat = vecs[i].lat_pm;
            r0 = pm_reads; w0 = pm_writes;
            do_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, lat, rdat);
            check($sformatf("vec%0d_lat", i), 128'(lat), 128'(vecs[i].exp_lat));
            if (vecs[i].rd) check($sformatf("vec%0d_rdata", i), rdat, vecs[i].exp_rdata);
            check($sformatf("vec%0d_preads", i), 128'(pm_reads - r0), 128'(vecs[i].exp_reads));
            check($sformatf("vec%0d_pwrites", i), 128'(pm_writes - w0), 128'(vecs[i].exp_writes));
        end
        check("no_merge_flush", pm_get(12'h777), D3);

        // ---- reset during a pending flush discards the buffered line ----
        pm_lat = 2;
        repeat (12) @(negedge clk);
        check("drain_d4", pm_get(12'h777), D4);
        pm_lat = 20;
        do_req(1'b0, 1'b1, 16'h1230, D5, lat, rdat);
        check("rf_write_lat", 128'(lat), 128'(1));
        k = 0;
        while (!pmem_write && k < 20) begin @(negedge clk); k++; end
        check("rf_flush_started", 128'(pmem_write), 128'(1));
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_outputs_zero("rf_reset_during");
        reset = 1'b0;
        @(negedge clk);
        check_outputs_zero("rf_reset_after");
        pm_lat = 2;
        r0 = pm_reads; w0 = pm_writes;
        do_req(1'b1, 1'b0, 16'h1234, 128'h0, lat, rdat);
        check("rf_read_lat", 128'(lat), 128'(3));
        check("rf_read_data", rdat, D1);
        check("rf_read_preads", 128'(pm_reads - r0), 128'(1));
        check("rf_no_writes", 128'(pm_writes - w0), 128'(0));

        // ---- randomized traffic against a line-level memory model ----
        lines = '{12'h123, 12'h124, 12'h456, 12'h777, 12'h999, 12'hFFF};
        for (int t = 0; t < 250; t++) begin
            logic [11:0] ln;
            logic [15:0] a;
            logic [127:0] wd;
            int op;
            repeat ($urandom_range(0, 4)) @(negedge clk);
            pm_lat = $urandom_range(1, 6);
            ln = lines[$urandom_range(0, 5)];
            a = {ln, 4'($urandom)};
            wd = {$urandom, $urandom, $urandom, $urandom};
            op = $urandom_range(0, 9);
            exp = ref_view.exists(ln) ? ref_view[ln] : pm_get(ln);
            if (op < 5 || op == 9) begin
                do_req(1'b1, op == 9, a, wd, lat, rdat);
                check($sformatf("rnd%0d_rdata", t), rdat, exp);
            end else begin
                do_req(1'b0, 1'b1, a, wd, lat, rdat);
                ref_view[ln] = wd;
            end
        end
        pm_lat = 2;
        repeat (30) @(negedge clk);
        foreach (ref_view[l]) check($sformatf("final_line_%h", l), pm_get(l), ref_view[l]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
